serial_adder: RTL and testbench

//  Bit-serial N-bit adder. Adds one bit per cycle, LSB first, through a full-adder

---
 rtl/serial_adder_pkg.sv | 14 +
 rtl/serial_adder_fa_cell.sv | 33 +++
 rtl/serial_adder.sv | 143 ++++++++++++++
 tb/tb_serial_adder.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
//   Shared types for the bit-serial adder.
//   sa_state_t : control FSM encoding (IDLE, SHIFT, DONE).
// -----------------------------------------------------------------------------
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sa_state_t;

endpackage

// File: rtl/serial_adder_fa_cell.sv
// -----------------------------------------------------------------------------
// fa_cell
//   One-bit full adder built from two half-adder stages and an OR.
//   Ports:
//     a, b : input  addend bits
//     ci   : input  carry in
//     s    : output sum bit
//     co   : output carry out
// -----------------------------------------------------------------------------
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic s1;
  logic c1;
  logic c2;

  // First half adder: a + b
  assign s1 = a ^ b;
  assign c1 = a & b;

  // Second half adder: partial sum + carry in
  assign s  = s1 ^ ci;
  assign c2 = s1 & ci;

  // The two half-adder carries can never both be 1, so OR suffices.
  assign co = c1 | c2;

endmodule

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//   Bit-serial WIDTH-bit adder, one bit per cycle, LSB first. Operands are
//   accepted over a valid/ready handshake, the result is offered over a second
//   valid/ready handshake. One fa_cell forms the whole datapath; the carry is
//   kept in a flop between bit cycles.
//
//   Parameters:
//     WIDTH        operand/result width (>= 1)
//   Ports:
//     clk          rising-edge clock
//     rst_n        asynchronous active-low reset
//     start_valid  operands a/b/cin present
//     start_ready  block can accept operands (IDLE)
//     a, b         operands, captured on accept
//     cin          carry in, captured on accept
//     result_valid sum/cout (and overflow) valid (DONE)
//     result_ready consumer takes the result
//     sum          (a+b+cin) mod 2^WIDTH
//     cout         carry out of bit WIDTH-1
//     busy         high in SHIFT or DONE
//     overflow     signed overflow, present only with SERIAL_ADDER_OVF_EN
//
//   Build option: define SERIAL_ADDER_OVF_EN to add the overflow output.
// -----------------------------------------------------------------------------
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             overflow,
`endif
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;

  sa_state_t        state;
  sa_state_t        next_state;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_next;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             bit_s;
  logic             bit_c;
  logic             accept;
  logic             last_bit;
  logic             release_result;

  // Per-bit datapath
  fa_cell u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .s  (bit_s),
    .co (bit_c)
  );

  // Outputs decoded straight from the state register: no input->output path.
  assign start_ready  = (state == IDLE);
  assign result_valid = (state == DONE);
  assign busy         = (state != IDLE);

  assign accept         = start_valid && (state == IDLE);
  assign release_result = result_ready && (state == DONE);
  assign last_bit       = (cnt == CW'(WIDTH - 1));

  // New sum bit enters at the MSB; written this way so WIDTH=1 needs no slice.
  always_comb begin
    sum_next            = sum >> 1;
    sum_next[WIDTH-1]   = bit_s;
  end

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic
  // NOTE: next_state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (accept)         next_state = SHIFT;
      SHIFT:   if (last_bit)       next_state = DONE;
      DONE:    if (release_result) next_state = IDLE;
      default:                     next_state = IDLE;
    endcase
  end

  // Datapath: operand capture, bit-serial add, result hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      sum   <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      cout  <= 1'b0;
    end else begin
      if (accept) begin
        a_sh  <= a;
        b_sh  <= b;
        carry <= cin;
        cnt   <= '0;
      end else if (state == SHIFT) begin
        a_sh  <= a_sh >> 1;
        b_sh  <= b_sh >> 1;
        sum   <= sum_next;
        carry <= bit_c;
        cnt   <= cnt + 1'b1;
        if (last_bit) cout <= bit_c;
      end
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  // On the last bit, 'carry' is the carry into the MSB and bit_c the carry out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          overflow <= 1'b0;
    else if (state == SHIFT && last_bit) overflow <= carry ^ bit_c;
  end
`endif

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//   Self-checking bench for serial_adder. A WIDTH=8 instance takes directed
//   and random operations; a WIDTH=1 instance covers the single-bit case.
//   Expected values come from plain integer arithmetic on the operands.
// -----------------------------------------------------------------------------
module tb_serial_adder;

  logic       clk;
  logic       rst_n;

  // WIDTH = 8 instance
  logic       start_valid;
  logic       start_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       result_valid;
  logic       result_ready;
  logic [7:0] sum;
  logic       cout;
  logic       busy;
  logic       overflow;

  // WIDTH = 1 instance
  logic       s1_start_valid;
  logic       s1_start_ready;
  logic [0:0] s1_a;
  logic [0:0] s1_b;
  logic       s1_cin;
  logic       s1_result_valid;
  logic       s1_result_ready;
  logic [0:0] s1_sum;
  logic       s1_cout;
  logic       s1_busy;
  logic       s1_overflow;

  int checks = 0;
  int errors = 0;

  serial_adder #(.WIDTH(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .a            (a),
    .b            (b),
    .cin          (cin),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .sum          (sum),
    .cout         (cout),
`ifdef SERIAL_ADDER_OVF_EN
    .overflow     (overflow),
`endif
    .busy         (busy)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_valid  (s1_start_valid),
    .start_ready  (s1_start_ready),
    .a            (s1_a),
    .b            (s1_b),
    .cin          (s1_cin),
    .result_valid (s1_result_valid),
    .result_ready (s1_result_ready),
    .sum          (s1_sum),
    .cout         (s1_cout),
`ifdef SERIAL_ADDER_OVF_EN
    .overflow     (s1_overflow),
`endif
    .busy         (s1_busy)
  );

`ifndef SERIAL_ADDER_OVF_EN
  assign overflow    = 1'b0;
  assign s1_overflow = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One WIDTH=8 operation. hold = cycles of result_ready=0 in DONE;
  // pulse = drive a spurious start_valid while shifting.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_,
                        input logic tcin, input int hold, input bit pulse);
    logic [8:0] total;
    logic       ovf_exp;
    int         edges;
    total   = 9'(ta) + 9'(tb_) + 9'(tcin);
    ovf_exp = (ta[7] == tb_[7]) && (total[7] != ta[7]);
    result_ready = (hold == 0);

    @(negedge clk);
    check("start_ready_idle", 32'(start_ready), 32'd1);
    start_valid = 1'b1;
    a = ta; b = tb_; cin = tcin;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    start_valid = 1'b0;
    a = ~ta; b = ~tb_; cin = ~tcin;
    check("busy_shift", 32'(busy), 32'd1);
    while (!result_valid && edges < 64) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      start_valid = pulse && (edges == 3);
      if (start_valid) begin
        a = 8'($urandom); b = 8'($urandom); cin = 1'b1;
      end
    end
    start_valid = 1'b0;
    // Accept edge plus WIDTH shift edges.
    check("latency_edges", 32'(edges), 32'd9);
    check("result_valid", 32'(result_valid), 32'd1);
    check("sum", 32'(sum), 32'(total[7:0]));
    check("cout", 32'(cout), 32'(total[8]));
`ifdef SERIAL_ADDER_OVF_EN
    check("overflow", 32'(overflow), 32'(ovf_exp));
`endif
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("hold_valid", 32'(result_valid), 32'd1);
      check("hold_sum", 32'(sum), 32'(total[7:0]));
      check("hold_cout", 32'(cout), 32'(total[8]));
    end
    result_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_valid", 32'(result_valid), 32'd0);
    check("post_ready", 32'(start_ready), 32'd1);
    check("post_busy", 32'(busy), 32'd0);
  endtask

  task automatic run_op1(input logic ta, input logic tb_, input logic tcin);
    logic [1:0] total;
    int         edges;
    total = 2'(ta) + 2'(tb_) + 2'(tcin);
    @(negedge clk);
    s1_start_valid = 1'b1;
    s1_a = ta; s1_b = tb_; s1_cin = tcin;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    s1_start_valid = 1'b0;
    while (!s1_result_valid && edges < 16) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    check("w1_latency", 32'(edges), 32'd2);
    check("w1_sum", 32'(s1_sum), 32'(total[0]));
    check("w1_cout", 32'(s1_cout), 32'(total[1]));
`ifdef SERIAL_ADDER_OVF_EN
    // Single-bit signed: overflow when carry-in to the bit differs from carry-out.
    check("w1_overflow", 32'(s1_overflow), 32'(tcin ^ total[1]));
`endif
    @(posedge clk);
    @(negedge clk);
    check("w1_post_valid", 32'(s1_result_valid), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    start_valid = 1'b0; a = '0; b = '0; cin = 1'b0; result_ready = 1'b1;
    s1_start_valid = 1'b0; s1_a = '0; s1_b = '0; s1_cin = 1'b0; s1_result_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(result_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_start_ready", 32'(start_ready), 32'd1);

    // Directed cases
    run_op(8'h0F, 8'h01, 1'b0, 0, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 0, 1'b0);
    run_op(8'h00, 8'h00, 1'b1, 0, 1'b0);
    run_op(8'h7F, 8'h01, 1'b0, 0, 1'b0);
    run_op(8'h80, 8'h80, 1'b0, 0, 1'b0);

    // Backpressure: 5 cycles of result_ready=0 in DONE
    run_op(8'hA5, 8'h3C, 1'b1, 5, 1'b0);

    // Spurious start_valid during SHIFT is ignored; no second result follows
    run_op(8'h12, 8'h34, 1'b0, 0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("no_second_result", 32'(result_valid), 32'd0);
      check("no_second_busy", 32'(busy), 32'd0);
    end

    // Reset after 3 SHIFT cycles
    @(negedge clk);
    start_valid = 1'b1; a = 8'hC3; b = 8'h5A; cin = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(result_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_sum", 32'(sum), 32'd0);
    check("midrst_cout", 32'(cout), 32'd0);
    check("midrst_ovf", 32'(overflow), 32'd0);
    check("midrst_ready", 32'(start_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8'h55, 8'hAA, 1'b1, 0, 1'b0);

    // Random operations with occasional backpressure
    for (int n = 0; n < 25; n++) begin
      run_op(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 2)), 1'b0);
    end

    // WIDTH = 1 instance
    run_op1(1'b1, 1'b1, 1'b0);
    run_op1(1'b0, 1'b1, 1'b1);
    run_op1(1'b1, 1'b0, 1'b0);
    run_op1(1'b0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
